// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage_if                                                |
// | Purpose  : Bundles the fetch-stage control inputs, the instruction-      |
// |            memory bus and the IF/ID pipeline-register outputs.           |
// | Ports    : stall, branch_taken, branch_target  (execute/downstream ctl)  |
// |            imem_addr, imem_data                 (instruction memory bus) |
// |            if_id_instr, if_id_pc, if_id_valid   (to decode)              |
// |            fetch_count, stall_count             (performance counters)   |
// | Modports : master - the fetch stage itself                               |
// |            slave  - the surrounding pipeline / memory                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic [DATA_WIDTH-1:0] if_id_instr;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic                  if_id_valid;
  logic [15:0]           fetch_count;
  logic [15:0]           stall_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, fetch_count, stall_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, fetch_count, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage                                                   |
// | Purpose  : Instruction-fetch stage. Owns the program counter, drives the |
// |            instruction-memory address and captures the returned word     |
// |            with its PC into the IF/ID pipeline register.                 |
// | Ports    : clock  - single clock, rising-edge                            |
// |            reset  - synchronous, active-high                             |
// |            bus    - fetch_stage_if.master (control, imem bus, IF/ID)     |
// | Config   : FETCH_PERF_CNT_EN - when defined, adds saturating 16-bit      |
// |            fetch/stall counters; otherwise both outputs are tied to 0.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_stage #(
  parameter int                         ADDR_WIDTH = 8,
  parameter int                         DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0]      NOP_WORD   = '0
) (
  input  wire logic       clock,
  input  wire logic       reset,
  fetch_stage_if.master   bus
);

  localparam logic [ADDR_WIDTH-1:0] c_pc_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_if_id_instr;
  logic [ADDR_WIDTH-1:0] r_if_id_pc;
  logic                  r_if_id_valid;

  // A branch overrides a simultaneous stall, so only a branch-free,
  // stall-free edge advances.
  logic w_advance;
  assign w_advance = !bus.branch_taken && !bus.stall;

  // Zero-wait memory: the address is the live PC.
  assign bus.imem_addr   = r_pc;
  assign bus.if_id_instr = r_if_id_instr;
  assign bus.if_id_pc    = r_if_id_pc;
  assign bus.if_id_valid = r_if_id_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_if_id_instr <= NOP_WORD;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      // The word at the old PC is dropped; a bubble goes to decode and the
      // target word is fetched on the next non-stalled edge.
      r_pc          <= bus.branch_target;
      r_if_id_instr <= NOP_WORD;
      r_if_id_pc    <= r_pc;
      r_if_id_valid <= 1'b0;
    end else if (w_advance) begin
      // imem_data is only sampled here, so X on the bus during stalls or
      // redirects never reaches the pipeline register.
      r_pc          <= r_pc + c_pc_one;
      r_if_id_instr <= bus.imem_data;
      r_if_id_pc    <= r_pc;
      r_if_id_valid <= 1'b1;
    end
    // Stall: everything holds.
  end

`ifdef FETCH_PERF_CNT_EN
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic [15:0] r_fetch_count;
  logic [15:0] r_stall_count;
  logic        w_stall_edge;

  assign w_stall_edge = bus.stall && !bus.branch_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_advance && (r_fetch_count != c_cnt_max)) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
      if (w_stall_edge && (r_stall_count != c_cnt_max)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign bus.fetch_count = r_fetch_count;
  assign bus.stall_count = r_stall_count;
`else
  assign bus.fetch_count = '0;
  assign bus.stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                |
// | Purpose  : Self-checking bench for fetch_stage. A reference PC model     |
// |            pushes the expected IF/ID contents for each edge into a       |
// |            scoreboard queue; they are popped and compared after the edge.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
    logic          valid;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_stage #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (8'h00),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr];

  exp_t    sb[$];
  exp_t    last_exp;
  logic [AW-1:0] mpc;
  int      m_fetch;
  int      m_stall;
  int      total  = 0;
  int      passed = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock edge: drive inputs, update model, push expectation, compare.
  task automatic step(input logic rst, input logic st, input logic br, input logic [AW-1:0] tgt);
    exp_t e;
    exp_t got;
    @(negedge clock);
    reset             = rst;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    if (!rst) chk("imem_addr_pre", {24'd0, bus.imem_addr}, {24'd0, mpc});
    if (rst) begin
      e = '{instr: 32'h0, pc: 8'h00, valid: 1'b0};
      mpc = 8'h00; m_fetch = 0; m_stall = 0;
    end else if (br) begin
      e = '{instr: 32'h0, pc: mpc, valid: 1'b0};
      mpc = tgt;
    end else if (st) begin
      e = last_exp;
      m_stall++;
    end else begin
      e = '{instr: mem[mpc], pc: mpc, valid: 1'b1};
      mpc = mpc + 8'd1;
      m_fetch++;
    end
    last_exp = e;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    chk("if_id_instr", bus.if_id_instr, got.instr);
    chk("if_id_pc",    {24'd0, bus.if_id_pc}, {24'd0, got.pc});
    chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, got.valid});
    chk("imem_addr",   {24'd0, bus.imem_addr}, {24'd0, mpc});
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", {16'd0, bus.fetch_count}, m_fetch);
    chk("stall_count", {16'd0, bus.stall_count}, m_stall);
`else
    chk("fetch_count", {16'd0, bus.fetch_count}, 32'd0);
    chk("stall_count", {16'd0, bus.stall_count}, 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 100);
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    mpc = '0; m_fetch = 0; m_stall = 0; last_exp = '0;

    // Reset, then five free-running fetches: 100..104 at pc 0..4.
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00);

    // PC wrap: jump to 0xFF, fetch it, continue from 0.
    step(0, 0, 1, 8'hFF);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // Stall three cycles at pc=7 with a valid word (pc 6) in IF/ID.
    step(0, 0, 1, 8'h06);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // Branch at pc=0x25 to 5: bubble, then imem[5] with pc 5.
    step(0, 0, 1, 8'h25);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h05);
    step(0, 0, 0, 8'h00);

    // Branch together with stall: branch wins.
    step(0, 1, 1, 8'h10);
    step(0, 0, 0, 8'h00);

    // Back-to-back branches, last one wins.
    step(0, 0, 1, 8'h40);
    step(0, 0, 1, 8'h50);
    step(0, 1, 1, 8'h60);
    step(0, 0, 0, 8'h00);

    // Branch to the current PC re-fetches the same word.
    step(0, 0, 1, mpc);
    step(0, 0, 0, 8'h00);

    // Stall while a bubble sits in IF/ID, then resume.
    step(0, 0, 1, 8'h80);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // Reset mid-run with branch and stall asserted.
    step(0, 1, 0, 8'h00);
    step(1, 1, 1, 8'h33);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
